// File: rtl/umi_router.sv
// umi_router: N-in / M-out UMI router. Input FIFOs, dstaddr route decode, and a per-output
// round-robin arbiter that stays locked until EOM. Optional macro: UMI_ROUTER_STATS_EN.
module umi_router #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int RSB   = 40,
  parameter int EOMB  = 22,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic [M-1:0]    umi_out_valid,
  output logic [M*CW-1:0] umi_out_cmd,
  output logic [M*AW-1:0] umi_out_dstaddr,
  output logic [M*AW-1:0] umi_out_srcaddr,
  output logic [M*DW-1:0] umi_out_data,
  input  logic [M-1:0]    umi_out_ready,
  output logic [N-1:0]    err_unroutable
`ifdef UMI_ROUTER_STATS_EN
  ,
  input  logic            clr_stats,
  output logic [M*16-1:0] pkt_count
`endif
);
  localparam int RW = $clog2(M);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] mem_cmd_q  [N][DEPTH];
  logic [AW-1:0] mem_dst_q  [N][DEPTH];
  logic [AW-1:0] mem_src_q  [N][DEPTH];
  logic [DW-1:0] mem_data_q [N][DEPTH];
  logic [PW:0]   wr_ptr_q [N], wr_ptr_d [N], rd_ptr_q [N], rd_ptr_d [N];
  logic [N-1:0]  head_q, head_d;
  logic [RW-1:0] route_q [N], route_d [N];
  logic          alive_q;
  logic [M-1:0]  lock_q, lock_d, hold_q, hold_d;
  logic [IW-1:0] owner_q [M], owner_d [M], ptr_q [M], ptr_d [M];

  logic [N-1:0]  push_s, pop_s, drop_s, nonempty_s, full_s, hd_eom_s;
  logic [CW-1:0] hd_cmd_s  [N];
  logic [AW-1:0] hd_dst_s  [N];
  logic [AW-1:0] hd_src_s  [N];
  logic [DW-1:0] hd_data_s [N];
  logic [RW-1:0] cur_route_s [N];
  logic [M-1:0]  req_s [N];
  logic [IW-1:0] gnt_s [M];
  logic [M-1:0]  gnt_ok_s, xfer_s, xfer_eom_s;

  // FIFO head view, route decode and input handshake
  always_comb begin
    for (int i = 0; i < N; i++) begin
      hd_cmd_s[i]    = mem_cmd_q[i][rd_ptr_q[i][PW-1:0]];
      hd_dst_s[i]    = mem_dst_q[i][rd_ptr_q[i][PW-1:0]];
      hd_src_s[i]    = mem_src_q[i][rd_ptr_q[i][PW-1:0]];
      hd_data_s[i]   = mem_data_q[i][rd_ptr_q[i][PW-1:0]];
      hd_eom_s[i]    = hd_cmd_s[i][EOMB];
      nonempty_s[i]  = (wr_ptr_q[i] != rd_ptr_q[i]);
      full_s[i]      = (wr_ptr_q[i] == {~rd_ptr_q[i][PW], rd_ptr_q[i][PW-1:0]});
      // body beats follow the route latched from their head, whatever their dstaddr says
      cur_route_s[i] = head_q[i] ? hd_dst_s[i][RSB+:RW] : route_q[i];
      drop_s[i]      = nonempty_s[i] & (int'(cur_route_s[i]) >= M);
      for (int j = 0; j < M; j++) begin
        req_s[i][j] = nonempty_s[i] & ~drop_s[i] & (int'(cur_route_s[i]) == j);
      end
      umi_in_ready[i]   = alive_q & ~full_s[i];
      push_s[i]         = umi_in_valid[i] & umi_in_ready[i];
      err_unroutable[i] = drop_s[i] & head_q[i];
    end
  end

  // Arbitration (output decode): grant, output mux, transfers and FIFO pops
  always_comb begin
    logic [IW-1:0] cand;
    cand            = {IW{1'b0}};
    umi_out_valid   = {M{1'b0}};
    umi_out_cmd     = {(M*CW){1'b0}};
    umi_out_dstaddr = {(M*AW){1'b0}};
    umi_out_srcaddr = {(M*AW){1'b0}};
    umi_out_data    = {(M*DW){1'b0}};
    for (int j = 0; j < M; j++) begin
      gnt_ok_s[j] = 1'b0;
      gnt_s[j]    = ptr_q[j];
      // a locked packet or a stalled beat keeps its owner so the output stays stable
      if (lock_q[j] || hold_q[j]) begin
        gnt_s[j]    = owner_q[j];
        gnt_ok_s[j] = req_s[owner_q[j]][j];
      end else begin
        for (int k = 0; k < N; k++) begin
          cand = IW'((int'(ptr_q[j]) + k) % N);
          if (!gnt_ok_s[j] && req_s[cand][j]) begin
            gnt_ok_s[j] = 1'b1;
            gnt_s[j]    = cand;
          end else begin
            gnt_ok_s[j] = gnt_ok_s[j];
          end
        end
      end
      umi_out_valid[j]             = gnt_ok_s[j];
      umi_out_cmd[j*CW+:CW]        = hd_cmd_s[gnt_s[j]];
      umi_out_dstaddr[j*AW+:AW]    = hd_dst_s[gnt_s[j]];
      umi_out_srcaddr[j*AW+:AW]    = hd_src_s[gnt_s[j]];
      umi_out_data[j*DW+:DW]       = hd_data_s[gnt_s[j]];
      xfer_s[j]                    = gnt_ok_s[j] & umi_out_ready[j];
      xfer_eom_s[j]                = hd_eom_s[gnt_s[j]];
    end
    pop_s = drop_s;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        if (xfer_s[j] && (gnt_s[j] == IW'(i))) begin
          pop_s[i] = 1'b1;
        end else begin
          pop_s[i] = pop_s[i];
        end
      end
    end
  end

  // Next state: FIFO pointers, packet HEAD/BODY tracking, arbiter IDLE/LOCKED
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + (PW+1)'(push_s[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + (PW+1)'(pop_s[i]);
      head_d[i]   = pop_s[i] ? hd_eom_s[i] : head_q[i];
      route_d[i]  = (pop_s[i] && head_q[i]) ? cur_route_s[i] : route_q[i];
    end
    for (int j = 0; j < M; j++) begin
      lock_d[j]  = lock_q[j];
      hold_d[j]  = 1'b0;
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      if (xfer_s[j]) begin
        if (xfer_eom_s[j]) begin
          lock_d[j] = 1'b0;
          ptr_d[j]  = (gnt_s[j] == IW'(N - 1)) ? {IW{1'b0}} : gnt_s[j] + IW'(1);
        end else begin
          lock_d[j]  = 1'b1;
          owner_d[j] = gnt_s[j];
        end
      end else if (gnt_ok_s[j] && !lock_q[j]) begin
        hold_d[j]  = 1'b1;
        owner_d[j] = gnt_s[j];
      end else begin
        hold_d[j] = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      alive_q <= 1'b0;
      head_q  <= {N{1'b1}};
      lock_q  <= {M{1'b0}};
      hold_q  <= {M{1'b0}};
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= {(PW+1){1'b0}};
        rd_ptr_q[i] <= {(PW+1){1'b0}};
        route_q[i]  <= {RW{1'b0}};
      end
      for (int j = 0; j < M; j++) begin
        owner_q[j] <= {IW{1'b0}};
        ptr_q[j]   <= {IW{1'b0}};
      end
    end else begin
      alive_q <= 1'b1;
      head_q  <= head_d;
      lock_q  <= lock_d;
      hold_q  <= hold_d;
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        route_q[i]  <= route_d[i];
      end
      for (int j = 0; j < M; j++) begin
        owner_q[j] <= owner_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
    end
  end

  // FIFO storage; occupancy lives in the pointers so the words need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push_s[i]) begin
        mem_cmd_q[i][wr_ptr_q[i][PW-1:0]]  <= umi_in_cmd[i*CW+:CW];
        mem_dst_q[i][wr_ptr_q[i][PW-1:0]]  <= umi_in_dstaddr[i*AW+:AW];
        mem_src_q[i][wr_ptr_q[i][PW-1:0]]  <= umi_in_srcaddr[i*AW+:AW];
        mem_data_q[i][wr_ptr_q[i][PW-1:0]] <= umi_in_data[i*DW+:DW];
      end
    end
  end

`ifdef UMI_ROUTER_STATS_EN
  logic [15:0] cnt_q [M], cnt_d [M];

  // Saturating per-output packet counters; clear wins over increment
  always_comb begin
    pkt_count = {(M*16){1'b0}};
    for (int j = 0; j < M; j++) begin
      if (clr_stats) begin
        cnt_d[j] = 16'h0000;
      end else if (xfer_s[j] && xfer_eom_s[j] && (cnt_q[j] != 16'hFFFF)) begin
        cnt_d[j] = cnt_q[j] + 16'h0001;
      end else begin
        cnt_d[j] = cnt_q[j];
      end
      pkt_count[j*16+:16] = cnt_q[j];
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int j = 0; j < M; j++) cnt_q[j] <= 16'h0000;
    end else begin
      for (int j = 0; j < M; j++) cnt_q[j] <= cnt_d[j];
    end
  end
`endif

endmodule

// File: tb/tb_umi_router.sv
// Directed self-checking bench for umi_router: a 4x4 instance and a 4x3 instance
// (the latter exercises unroutable packets). Honours UMI_ROUTER_STATS_EN.
module tb_umi_router;
  localparam int N = 4, M = 4, M3 = 3, DW = 256, AW = 64, CW = 32;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid, in_ready, err;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst, in_src;
  logic [N*DW-1:0] in_data;
  logic [M-1:0]    out_valid, out_ready;
  logic [M*CW-1:0] out_cmd;
  logic [M*AW-1:0] out_dst, out_src;
  logic [M*DW-1:0] out_data;

  logic [N-1:0]     s_valid, s_ready, s_err;
  logic [N*CW-1:0]  s_cmd;
  logic [N*AW-1:0]  s_dst, s_src;
  logic [N*DW-1:0]  s_data;
  logic [M3-1:0]    s_out_valid, s_out_ready;
  logic [M3*CW-1:0] s_out_cmd;
  logic [M3*AW-1:0] s_out_dst, s_out_src;
  logic [M3*DW-1:0] s_out_data;

`ifdef UMI_ROUTER_STATS_EN
  logic            clr_stats, s_clr_stats;
  logic [M*16-1:0]  pkt_count;
  logic [M3*16-1:0] s_pkt_count;
`endif

  umi_router #(.N(N), .M(M)) dut (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready),
    .err_unroutable(err)
`ifdef UMI_ROUTER_STATS_EN
    , .clr_stats(clr_stats), .pkt_count(pkt_count)
`endif
  );

  umi_router #(.N(N), .M(M3)) dut3 (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(s_valid), .umi_in_cmd(s_cmd), .umi_in_dstaddr(s_dst),
    .umi_in_srcaddr(s_src), .umi_in_data(s_data), .umi_in_ready(s_ready),
    .umi_out_valid(s_out_valid), .umi_out_cmd(s_out_cmd), .umi_out_dstaddr(s_out_dst),
    .umi_out_srcaddr(s_out_src), .umi_out_data(s_out_data), .umi_out_ready(s_out_ready),
    .err_unroutable(s_err)
`ifdef UMI_ROUTER_STATS_EN
    , .clr_stats(s_clr_stats), .pkt_count(s_pkt_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  beat_t qin [N][$];
  beat_t obs [M][$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input beat_t got, input beat_t exp);
    check_eq({tag, "_cmd"}, 256'(got.cmd), 256'(exp.cmd));
    check_eq({tag, "_dst"}, 256'(got.dst), 256'(exp.dst));
    check_eq({tag, "_data"}, got.data, exp.data);
  endtask

  function automatic beat_t mk_beat(input logic [7:0] route, input logic eom, input logic [7:0] tag);
    beat_t b;
    b.cmd  = {9'd0, eom, 14'd0, tag};
    b.dst  = {16'd0, route, 32'd0, tag};
    b.src  = {48'hA5A5_0000_0000, 8'h00, tag};
    b.data = {4{56'hC0FFEE_0000_0000, tag}};
    return b;
  endfunction

  // One cycle per iteration: present queue heads, log output transfers, retire accepts.
  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    beat_t b;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (qin[i].size() > 0) begin
          in_valid[i]         = 1'b1;
          in_cmd[i*CW+:CW]    = qin[i][0].cmd;
          in_dst[i*AW+:AW]    = qin[i][0].dst;
          in_src[i*AW+:AW]    = qin[i][0].src;
          in_data[i*DW+:DW]   = qin[i][0].data;
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      #1;
      acc = in_valid & in_ready;
      for (int j = 0; j < M; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          b.cmd  = out_cmd[j*CW+:CW];
          b.dst  = out_dst[j*AW+:AW];
          b.src  = out_src[j*AW+:AW];
          b.data = out_data[j*DW+:DW];
          obs[j].push_back(b);
        end
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) if (acc[i]) void'(qin[i].pop_front());
      #1;
      in_valid = '0;
    end
  endtask

  task automatic clear_obs();
    for (int j = 0; j < M; j++) obs[j].delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t b, e;
    int err_cnt;
    logic [M3-1:0] seen_valid;
    int sidx;
    beat_t sb [2];

    in_valid = '0; in_cmd = '0; in_dst = '0; in_src = '0; in_data = '0;
    out_ready = 4'hF;
    s_valid = '0; s_cmd = '0; s_dst = '0; s_src = '0; s_data = '0;
    s_out_ready = 3'b111;
`ifdef UMI_ROUTER_STATS_EN
    clr_stats = 1'b0; s_clr_stats = 1'b0;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 256'(in_ready), 256'(4'h0));
    check_eq("rst_out_valid", 256'(out_valid), 256'(4'h0));
    check_eq("rst_err", 256'(err), 256'(4'h0));
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", 256'(in_ready), 256'(4'hF));
`ifdef UMI_ROUTER_STATS_EN
    check_eq("rst_pkt_count", 256'(pkt_count), 256'(0));
`endif

    // single beat input 0 -> output 2, visible one cycle after accept
    e = mk_beat(8'd2, 1'b1, 8'h11);
    qin[0].push_back(e);
    run_cycles(1);
    check_eq("t1_out_valid", 256'(out_valid), 256'(4'b0100));
    check_eq("t1_cmd", 256'(out_cmd[2*CW+:CW]), 256'(e.cmd));
    check_eq("t1_dst", 256'(out_dst[2*AW+:AW]), 256'(e.dst));
    check_eq("t1_src", 256'(out_src[2*AW+:AW]), 256'(e.src));
    check_eq("t1_data", out_data[2*DW+:DW], e.data);
    run_cycles(1);
    check_eq("t1_drained", 256'(out_valid), 256'(4'b0000));
    check_eq("t1_obs_n", 256'(obs[2].size()), 256'(1));
`ifdef UMI_ROUTER_STATS_EN
    check_eq("t1_pkt_count2", 256'(pkt_count[2*16+:16]), 256'(16'd1));
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    @(posedge clk); #1;
    check_eq("t1_clr_stats", 256'(pkt_count), 256'(0));
`endif

    // three simultaneous requesters on output 1: round-robin order 0,1,3
    clear_obs();
    qin[0].push_back(mk_beat(8'd1, 1'b1, 8'h20));
    qin[1].push_back(mk_beat(8'd1, 1'b1, 8'h21));
    qin[3].push_back(mk_beat(8'd1, 1'b1, 8'h23));
    run_cycles(6);
    check_eq("t2_obs_n", 256'(obs[1].size()), 256'(3));
    check_beat("t2_b0", obs[1][0], mk_beat(8'd1, 1'b1, 8'h20));
    check_beat("t2_b1", obs[1][1], mk_beat(8'd1, 1'b1, 8'h21));
    check_beat("t2_b2", obs[1][2], mk_beat(8'd1, 1'b1, 8'h23));
    // pointer wrapped to 0: input 0 beats input 3
    clear_obs();
    qin[3].push_back(mk_beat(8'd1, 1'b1, 8'h33));
    qin[0].push_back(mk_beat(8'd1, 1'b1, 8'h30));
    run_cycles(5);
    check_eq("t2p_obs_n", 256'(obs[1].size()), 256'(2));
    check_beat("t2p_first", obs[1][0], mk_beat(8'd1, 1'b1, 8'h30));
    check_beat("t2p_second", obs[1][1], mk_beat(8'd1, 1'b1, 8'h33));

    // 4-beat packet locks output 0; body beats carry route 3 but stay on output 0
    clear_obs();
    qin[2].push_back(mk_beat(8'd0, 1'b0, 8'h50));
    qin[2].push_back(mk_beat(8'd3, 1'b0, 8'h51));
    qin[2].push_back(mk_beat(8'd3, 1'b0, 8'h52));
    qin[2].push_back(mk_beat(8'd3, 1'b1, 8'h53));
    run_cycles(1);
    qin[1].push_back(mk_beat(8'd0, 1'b1, 8'h60));
    run_cycles(10);
    check_eq("t3_obs_n", 256'(obs[0].size()), 256'(5));
    check_beat("t3_b0", obs[0][0], mk_beat(8'd0, 1'b0, 8'h50));
    check_beat("t3_b1", obs[0][1], mk_beat(8'd3, 1'b0, 8'h51));
    check_beat("t3_b2", obs[0][2], mk_beat(8'd3, 1'b0, 8'h52));
    check_beat("t3_b3", obs[0][3], mk_beat(8'd3, 1'b1, 8'h53));
    check_beat("t3_b4", obs[0][4], mk_beat(8'd0, 1'b1, 8'h60));
    check_eq("t3_out3_idle", 256'(obs[3].size()), 256'(0));

    // backpressure on output 3
    clear_obs();
    out_ready = 4'b0111;
    for (int k = 0; k < 5; k++) qin[0].push_back(mk_beat(8'd3, 1'b1, 8'(8'h70 + k)));
    run_cycles(3);
    e = mk_beat(8'd3, 1'b1, 8'h70);
    check_eq("t4_in_ready0", 256'(in_ready[0]), 256'(1'b0));
    check_eq("t4_accepted", 256'(qin[0].size()), 256'(3));
    check_eq("t4_valid", 256'(out_valid), 256'(4'b1000));
    check_eq("t4_cmd", 256'(out_cmd[3*CW+:CW]), 256'(e.cmd));
    run_cycles(7);
    check_eq("t4_valid_hold", 256'(out_valid), 256'(4'b1000));
    check_eq("t4_cmd_hold", 256'(out_cmd[3*CW+:CW]), 256'(e.cmd));
    check_eq("t4_data_hold", out_data[3*DW+:DW], e.data);
    check_eq("t4_in_ready0_hold", 256'(in_ready[0]), 256'(1'b0));
    out_ready = 4'hF;
    run_cycles(10);
    check_eq("t4_obs_n", 256'(obs[3].size()), 256'(5));
    for (int k = 0; k < 5; k++) check_beat("t4_drain", obs[3][k], mk_beat(8'd3, 1'b1, 8'(8'h70 + k)));
    check_eq("t4_q_empty", 256'(qin[0].size()), 256'(0));

    // unroutable 2-beat packet on the 3-output instance
    sb[0] = mk_beat(8'd3, 1'b0, 8'h80);
    sb[1] = mk_beat(8'd3, 1'b1, 8'h81);
    sidx = 0; err_cnt = 0; seen_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sidx < 2) begin
        s_valid[1] = 1'b1;
        s_cmd[CW+:CW] = sb[sidx].cmd; s_dst[AW+:AW] = sb[sidx].dst;
        s_src[AW+:AW] = sb[sidx].src; s_data[DW+:DW] = sb[sidx].data;
      end else begin
        s_valid[1] = 1'b0;
      end
      #1;
      if (s_err[1]) err_cnt++;
      seen_valid = seen_valid | s_out_valid;
      check_eq("t5_err_other", 256'({s_err[3:2], s_err[0]}), 256'(3'b000));
      @(posedge clk);
      if (s_valid[1] && s_ready[1]) sidx++;
    end
    #1;
    s_valid = '0;
    check_eq("t5_err_pulses", 256'(err_cnt), 256'(1));
    check_eq("t5_no_out_valid", 256'(seen_valid), 256'(3'b000));
    check_eq("t5_both_accepted", 256'(sidx), 256'(2));
    b = mk_beat(8'd0, 1'b1, 8'h88);
    @(negedge clk);
    s_valid[1] = 1'b1;
    s_cmd[CW+:CW] = b.cmd; s_dst[AW+:AW] = b.dst; s_src[AW+:AW] = b.src; s_data[DW+:DW] = b.data;
    @(posedge clk);
    #1;
    s_valid = '0;
    check_eq("t5_after_valid", 256'(s_out_valid), 256'(3'b001));
    check_eq("t5_after_cmd", 256'(s_out_cmd[0+:CW]), 256'(b.cmd));

    // reset in the middle of a 4-beat packet
    clear_obs();
    for (int k = 0; k < 4; k++) qin[0].push_back(mk_beat(8'd1, (k == 3), 8'(8'h90 + k)));
    run_cycles(2);
    check_eq("t6_mid_valid", 256'(out_valid), 256'(4'b0010));
    nreset = 1'b0;
    #1;
    check_eq("t6_rst_valid", 256'(out_valid), 256'(4'b0000));
    check_eq("t6_rst_ready", 256'(in_ready), 256'(4'b0000));
    qin[0].delete();
    clear_obs();
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
`ifdef UMI_ROUTER_STATS_EN
    check_eq("t6_pkt_count", 256'(pkt_count), 256'(0));
`endif
    e = mk_beat(8'd2, 1'b1, 8'hA0);
    qin[0].push_back(e);
    run_cycles(3);
    check_eq("t6_obs2_n", 256'(obs[2].size()), 256'(1));
    check_beat("t6_fresh", obs[2][0], e);
    check_eq("t6_obs1_n", 256'(obs[1].size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
